// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the FFT sequencer.
// Holds FSM state encoding, size defaults and the OP_CUSTOM0 opcode.
package fft_pkg;

   localparam int MAX_LOG2N_DEF = 10;
   localparam int ELEM_BYTES_DEF = 4;

   // Must stay in sync with OP_CUSTOM0 in opcodes.vh.
   localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } fft_state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: butterfly operand addresses and twiddle index.
// Ports: s, b, log2n, base in; addr_a, addr_b, tw_idx out (comb).
module fft_addr_gen
   import fft_pkg::*;
#(
   parameter int MAX_LOG2N = MAX_LOG2N_DEF,
   parameter int ADDR_W = 32,
   parameter int ELEM_BYTES = ELEM_BYTES_DEF
) (
   input  logic [3:0]           s,
   input  logic [MAX_LOG2N-2:0] b,
   input  logic [3:0]           log2n,
   input  logic [ADDR_W-1:0]    base,
   output logic [ADDR_W-1:0]    addr_a,
   output logic [ADDR_W-1:0]    addr_b,
   output logic [MAX_LOG2N-2:0] tw_idx
);

   localparam logic [MAX_LOG2N-1:0] N_ONE = 1;

   logic [MAX_LOG2N-1:0] b_w;
   logic [MAX_LOG2N-1:0] half;
   logic [MAX_LOG2N-1:0] pos;
   logic [MAX_LOG2N-1:0] idx_a;
   logic [MAX_LOG2N-1:0] idx_b;
   logic [3:0]           tw_sh;

   assign b_w = {1'b0, b};
   assign half = N_ONE << s;
   assign pos = b_w & (half - N_ONE);

   // Group number selects the 2*half block, pos the offset inside it.
   assign idx_a = ((b_w >> s) << (s + 4'd1)) | pos;
   assign idx_b = idx_a + half;

   // pos < half <= N/2, so it always fits the narrower index.
   assign tw_sh = log2n - 4'd1 - s;
   assign tw_idx = pos[MAX_LOG2N-2:0] << tw_sh;

   assign addr_a = base
      + ADDR_W'(idx_a) * ADDR_W'(ELEM_BYTES);
   assign addr_b = base
      + ADDR_W'(idx_b) * ADDR_W'(ELEM_BYTES);

endmodule

// File: rtl/fft_sequencer.sv
// fft_sequencer: walks stages/butterflies of an in-place radix-2 FFT.
// Ports: clk, rst_n; fft_start/base/log2n in; fft_busy/done/err out;
//        bf_valid/addr_a/addr_b/tw_idx out, bf_ready/bf_done in.
module fft_sequencer
   import fft_pkg::*;
#(
   parameter int MAX_LOG2N = MAX_LOG2N_DEF,
   parameter int ADDR_W = 32,
   parameter int ELEM_BYTES = ELEM_BYTES_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 fft_start,
   input  logic [ADDR_W-1:0]    fft_base,
   input  logic [3:0]           fft_log2n,
   output logic                 fft_busy,
   output logic                 fft_done,
   output logic                 fft_err,
   output logic                 bf_valid,
   input  logic                 bf_ready,
   output logic [ADDR_W-1:0]    bf_addr_a,
   output logic [ADDR_W-1:0]    bf_addr_b,
   output logic [MAX_LOG2N-2:0] bf_tw_idx,
   input  logic                 bf_done
);

   localparam logic [3:0] MAX_L = 4'(MAX_LOG2N);
   localparam logic [MAX_LOG2N-1:0] N_ONE = 1;
   localparam logic [MAX_LOG2N-2:0] B_ONE = 1;

   fft_state_t           state;
   fft_state_t           state_n;
   logic [3:0]           s;
   logic [3:0]           s_n;
   logic [MAX_LOG2N-2:0] b;
   logic [MAX_LOG2N-2:0] b_n;
   logic [ADDR_W-1:0]    base_r;
   logic [ADDR_W-1:0]    base_n;
   logic [3:0]           log2n_r;
   logic [3:0]           log2n_n;
   logic                 err_n;

   logic [MAX_LOG2N-1:0] n_half;
   logic                 b_last;
   logic                 s_last;
   logic [ADDR_W-1:0]    ag_a;
   logic [ADDR_W-1:0]    ag_b;
   logic [MAX_LOG2N-2:0] ag_tw;

   fft_addr_gen #(
      .MAX_LOG2N  (MAX_LOG2N),
      .ADDR_W     (ADDR_W),
      .ELEM_BYTES (ELEM_BYTES)
   ) u_addr_gen (
      .s      (s),
      .b      (b),
      .log2n  (log2n_r),
      .base   (base_r),
      .addr_a (ag_a),
      .addr_b (ag_b),
      .tw_idx (ag_tw)
   );

   assign n_half = N_ONE << (log2n_r - 4'd1);
   assign b_last = ({1'b0, b} == (n_half - N_ONE));
   assign s_last = (s == (log2n_r - 4'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         s       <= '0;
         b       <= '0;
         base_r  <= '0;
         log2n_r <= '0;
         fft_err <= 1'b0;
      end else begin
         state   <= state_n;
         s       <= s_n;
         b       <= b_n;
         base_r  <= base_n;
         log2n_r <= log2n_n;
         fft_err <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      s_n     = s;
      b_n     = b;
      base_n  = base_r;
      log2n_n = log2n_r;
      err_n   = fft_err;
      unique case (state)
         IDLE: begin
            if (fft_start) begin
               base_n  = fft_base;
               log2n_n = fft_log2n;
               err_n   = 1'b0;
               s_n     = '0;
               b_n     = '0;
               if (fft_log2n == 4'd0) begin
                  state_n = DONE;
               end else if (fft_log2n > MAX_L) begin
                  err_n   = 1'b1;
                  state_n = DONE;
               end else begin
                  state_n = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (bf_ready) state_n = WAIT;
         end
         WAIT: begin
            if (bf_done) begin
               if (!b_last) begin
                  b_n     = b + B_ONE;
                  state_n = ISSUE;
               end else if (!s_last) begin
                  s_n     = s + 4'd1;
                  b_n     = '0;
                  state_n = ISSUE;
               end else begin
                  state_n = DONE;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign fft_busy = (state != IDLE);
   assign fft_done = (state == DONE);
   assign bf_valid = (state == ISSUE);

   // Addresses are only meaningful while a request is offered.
   assign bf_addr_a = bf_valid ? ag_a : '0;
   assign bf_addr_b = bf_valid ? ag_b : '0;
   assign bf_tw_idx = bf_valid ? ag_tw : '0;

endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: randomized self-checking bench for fft_sequencer.
// Reference model enumerates DIT butterflies as group/offset loops.
module tb_fft_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fft_start = 1'b0;
   logic [31:0] fft_base = '0;
   logic [3:0]  fft_log2n = '0;
   logic        fft_busy;
   logic        fft_done;
   logic        fft_err;
   logic        bf_valid;
   logic        bf_ready = 1'b0;
   logic [31:0] bf_addr_a;
   logic [31:0] bf_addr_b;
   logic [8:0]  bf_tw_idx;
   logic        bf_done = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [31:0] ea[$];
   logic [31:0] eb[$];
   logic [31:0] et[$];

   fft_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fft_start (fft_start),
      .fft_base  (fft_base),
      .fft_log2n (fft_log2n),
      .fft_busy  (fft_busy),
      .fft_done  (fft_done),
      .fft_err   (fft_err),
      .bf_valid  (bf_valid),
      .bf_ready  (bf_ready),
      .bf_addr_a (bf_addr_a),
      .bf_addr_b (bf_addr_b),
      .bf_tw_idx (bf_tw_idx),
      .bf_done   (bf_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h",
                tag, obs, exp);
      end
   endtask

   task automatic build(input logic [31:0] base, input int l2);
      int n;
      int half;
      int groups;
      logic [31:0] ia;
      logic [31:0] ib;
      ea.delete();
      eb.delete();
      et.delete();
      if (l2 == 0 || l2 > 10) return;
      n = 1 << l2;
      for (int st = 0; st < l2; st++) begin
         half = 1 << st;
         groups = n / (2 * half);
         for (int g = 0; g < groups; g++) begin
            for (int j = 0; j < half; j++) begin
               ia = 32'(g * 2 * half + j);
               ib = ia + 32'(half);
               ea.push_back(base + ia * 32'd4);
               eb.push_back(base + ib * 32'd4);
               et.push_back(32'(j * groups));
            end
         end
      end
   endtask

   task automatic run_fft(input logic [31:0] base,
                          input logic [3:0] l2,
                          input bit stall,
                          input bit restart);
      int busy = 0;
      int dones = 0;
      int reqs = 0;
      int cyc = 0;
      int cnt = 0;
      int nexp;
      bit pend = 0;
      bit seen = 0;
      build(base, int'(l2));
      nexp = ea.size();
      @(negedge clk);
      fft_start = 1'b1;
      fft_base = base;
      fft_log2n = l2;
      bf_ready = 1'b0;
      bf_done = 1'b0;
      @(negedge clk);
      fft_start = 1'b0;
      fft_base = $urandom;
      fft_log2n = 4'($urandom);
      while (!seen && cyc < 30000) begin
         cyc++;
         busy += int'(fft_busy);
         if (fft_done) begin
            dones++;
            seen = 1;
            chk("done_busy", fft_busy, 1);
         end
         bf_done = 1'b0;
         bf_ready = 1'b0;
         fft_start = 1'b0;
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               bf_done = 1'b1;
               pend = 0;
            end
         end
         if (bf_valid) begin
            if (reqs < nexp) begin
               chk("addr_a", bf_addr_a, ea[reqs]);
               chk("addr_b", bf_addr_b, eb[reqs]);
               chk("tw_idx", bf_tw_idx, et[reqs]);
            end else begin
               chk("extra_req", reqs, nexp - 1);
            end
            bf_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (bf_ready) begin
               reqs++;
               pend = 1;
               cnt = stall ? int'($urandom_range(1, 3)) : 1;
            end else if (stall && $urandom_range(0, 1) == 1) begin
               bf_done = 1'b1;
            end
         end
         if (restart && cyc == 7) begin
            fft_start = 1'b1;
            fft_base = base ^ 32'h0000_5A50;
            fft_log2n = 4'd2;
         end
         if (!seen) @(negedge clk);
      end
      bf_ready = 1'b0;
      bf_done = 1'b0;
      fft_start = 1'b0;
      chk("done_seen", seen, 1);
      chk("req_count", reqs, nexp);
      chk("done_pulses", dones, 1);
      chk("err_flag", fft_err, l2 > 4'd10);
      if (!stall) begin
         chk("busy_cycles", busy, 2 * nexp + 1);
         chk("done_cycle", cyc, 2 * nexp + 1);
      end
      @(negedge clk);
      chk("idle_busy", fft_busy, 0);
      chk("idle_done", fft_done, 0);
      chk("idle_valid", bf_valid, 0);
      chk("err_sticky", fft_err, l2 > 4'd10);
   endtask

   initial begin
      int acc;
      bit pnd;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", fft_busy, 0);
      chk("rst_done", fft_done, 0);
      chk("rst_err", fft_err, 0);
      chk("rst_valid", bf_valid, 0);
      chk("rst_addr_a", bf_addr_a, 0);
      chk("rst_addr_b", bf_addr_b, 0);
      chk("rst_tw", bf_tw_idx, 0);
      rst_n = 1'b1;

      @(negedge clk);
      bf_done = 1'b1;
      @(negedge clk);
      bf_done = 1'b0;
      chk("idle_spur_busy", fft_busy, 0);
      chk("idle_spur_valid", bf_valid, 0);

      run_fft(32'h100, 4'd3, 0, 0);
      run_fft(32'h100, 4'd3, 1, 0);
      run_fft($urandom, 4'd0, 0, 0);
      run_fft($urandom, 4'd12, 0, 0);
      run_fft($urandom, 4'd11, 0, 0);
      run_fft($urandom, 4'd4, 0, 0);
      run_fft(32'h2000, 4'd4, 0, 1);
      run_fft(32'hFFFF_FFF0, 4'd3, 0, 0);
      run_fft($urandom, 4'd1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         run_fft($urandom, 4'($urandom_range(1, 5)), 1, 0);
      end
      run_fft($urandom, 4'd10, 0, 0);

      @(negedge clk);
      fft_start = 1'b1;
      fft_base = 32'h400;
      fft_log2n = 4'd3;
      bf_ready = 1'b1;
      acc = 0;
      pnd = 0;
      for (int k = 0; k < 100 && acc < 5; k++) begin
         @(negedge clk);
         fft_start = 1'b0;
         bf_done = pnd;
         pnd = 0;
         if (bf_valid) begin
            acc++;
            pnd = 1;
         end
      end
      @(posedge clk);
      #1;
      chk("abort_accepts", acc, 5);
      chk("abort_wait_valid", bf_valid, 0);
      chk("abort_wait_busy", fft_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", fft_busy, 0);
      chk("arst_done", fft_done, 0);
      chk("arst_err", fft_err, 0);
      chk("arst_valid", bf_valid, 0);
      chk("arst_addr_a", bf_addr_a, 0);
      chk("arst_addr_b", bf_addr_b, 0);
      chk("arst_tw", bf_tw_idx, 0);
      bf_ready = 1'b0;
      bf_done = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_fft(32'h300, 4'd3, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
- Sequences an in-place radix-2 DIT FFT over data memory after the control unit decodes an OP_CUSTOM0 instruction and asserts FFTStart.
- Latches the base address and transform size, then walks every stage and butterfly.
- Issues one butterfly at a time to the butterfly datapath using a valid/ready request and a done completion pulse.
- Holds the CPU pipeline stalled until the whole transform completes.

Parameters:
- MAX_LOG2N, 10, largest supported log2 of transform size.
- ADDR_W, 32, byte-address width.
- ELEM_BYTES, 4, bytes per complex sample (16-bit re/im packed).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- fft_start  in  1  FFTStart from control_unit; one-cycle request.
- fft_base  in  ADDR_W  base byte address (rs1 value), sampled with fft_start.
- fft_log2n  in  4  log2 of transform size (rs2[3:0]), sampled with fft_start.
- fft_busy  out  1  pipeline stall request.
- fft_done  out  1  one-cycle completion pulse.
- fft_err  out  1  sticky error flag; cleared by the next accepted start.
- bf_valid  out  1  butterfly request valid.
- bf_ready  in  1  butterfly unit accepts the request.
- bf_addr_a  out  ADDR_W  byte address of the upper operand.
- bf_addr_b  out  ADDR_W  byte address of the lower operand.
- bf_tw_idx  out  MAX_LOG2N-1  twiddle ROM index.
- bf_done  in  1  butterfly result written back.

Behaviour:
- Clock and reset: single clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE; all outputs 0; stage, butterfly, base and log2n registers 0.
- Reset mid-operation: the sequencer returns to IDLE immediately. Any outstanding butterfly is abandoned, and the butterfly unit is reset by the same rst_n.
- Input ordering: input data must already be in bit-reversed order. No reorder pass is performed.

State machine:
- IDLE, with fft_start=1 in cycle T:
  - Latch fft_base and fft_log2n; clear fft_err.
  - If log2n==0, go to DONE.
  - If log2n>MAX_LOG2N, set fft_err and go to DONE.
  - Otherwise clear s and b, and go to ISSUE.
  - fft_busy=1 from T+1.
- ISSUE: bf_valid=1 with stable addresses and index. Stay until bf_valid && bf_ready, then go to WAIT.
- WAIT: bf_valid=0. Only on bf_done:
  - If b<N/2-1: b++ and go to ISSUE.
  - Else, if s<log2n-1: s++, b=0, go to ISSUE.
  - Else go to DONE.
- DONE: fft_done=1 and fft_busy=1 for exactly one cycle, then IDLE with fft_busy=0.

Handshake and input rules:
- bf_done is ignored outside WAIT.
- The butterfly unit guarantees at least one cycle from acceptance to bf_done.
- fft_start while not IDLE is ignored, with no effect on the latched registers.

Address arithmetic (unsigned, with N=1<<log2n, half=1<<s, pos=b&(half-1)):
- idx_a = ((b>>s)<<(s+1)) | pos.
- idx_b = idx_a + half.
- bf_tw_idx = pos << (log2n-1-s).
- bf_addr_x = base + idx_x*ELEM_BYTES, truncated to ADDR_W (wraps silently).

Latency:
- With bf_ready=1 and bf_done one cycle after acceptance, each butterfly takes 2 cycles.
- Total fft_busy duration = log2n*(N/2)*2 + 1 cycles.

Decomposition:
- fft_pkg holds:
  - state encoding localparams: IDLE, ISSUE, WAIT, DONE;
  - MAX_LOG2N and ELEM_BYTES defaults;
  - the OP_CUSTOM0 opcode value, shared with opcodes.vh.
- Sub-module fft_addr_gen (purely combinational): maps s, b, log2n and base to addr_a, addr_b and tw_idx. It is unit-tested separately.

Test Plan:
- log2n=3, base=0x100, bf_ready=1, done latency 1:
  - first request: s0 b0 → addr_a=0x100, addr_b=0x104, tw=0;
  - s1 b1 → 0x104/0x10C, tw=2;
  - s2 b3 → 0x10C/0x11C, tw=3;
  - exactly 12 requests; fft_busy high for 25 cycles; one fft_done pulse.
- bf_ready low for 3 cycles in ISSUE → bf_valid and addresses held stable; no state advance; no duplicate request.
- Spurious bf_done in ISSUE and IDLE → ignored; butterfly count unchanged.
- log2n=0 → fft_done at T+1, with no bf_valid.
- log2n=12 → fft_err=1 with fft_done at T+1.
- The next valid start clears fft_err.
- Second fft_start with a different base mid-run → ignored; addresses continue from the original base.
- rst_n asserted during WAIT at stage 1 → all outputs 0 asynchronously. A subsequent start runs a full clean transform.
